regfl_win: RTL

- Parametrised successor to the flat register file in the SHA-2 IPU data path.
- Holds 2^w words of rgst_w bits each, with three update modes:
  - addressed write, as in the existing register file;
  - shift-in sliding window, which is the SHA-2 message-schedule W[t-16..t-1] window;
  - synchronous clear.
- Adds a registered random-read port and a saturating fill counter, so the control FSM knows when the window holds a full block.

---
 rtl/regfl_win.sv | 103 ++++++++++
 1 files changed

// File: rtl/regfl_win.sv
// Windowed register file: addressed write, shift-in sliding window, sync clear,
// registered random read and saturating fill counter. Macro REGFL_WIN_BYPASS_EN selects write-through read.
module regfl_win #(
    parameter int w      = 3,
    parameter int rgst_w = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       sh,
    input  logic                       we,
    input  logic [rgst_w-1:0]          d,
    input  logic [w-1:0]               s,
    input  logic [w-1:0]               rs,
    output logic [(1<<w)*rgst_w-1:0]   q,
    output logic [rgst_w-1:0]          rq,
    output logic [w:0]                 cnt,
    output logic                       full
);

    localparam int D = 1 << w;
    localparam logic [w:0] D_CNT = {1'b1, {w{1'b0}}};

    logic [rgst_w-1:0] r_mem [D];
    logic [rgst_w-1:0] w_mem_nxt [D];
    logic [w:0]        r_cnt;
    logic [w:0]        w_cnt_nxt;
    logic [rgst_w-1:0] r_rq;
    logic [rgst_w-1:0] w_rq_nxt;

    // Next-state of the entries: clear beats shift beats addressed write.
    always_comb begin
        for (int i = 0; i < D; i++) begin
            w_mem_nxt[i] = r_mem[i];
        end
        if (clr) begin
            for (int i = 0; i < D; i++) begin
                w_mem_nxt[i] = '0;
            end
        end else if (sh) begin
            for (int i = 0; i < D - 1; i++) begin
                w_mem_nxt[i] = r_mem[i+1];
            end
            w_mem_nxt[D-1] = d;
        end else if (we) begin
            w_mem_nxt[s] = d;
        end else begin
            w_mem_nxt[0] = r_mem[0];
        end
    end

    // Fill counter saturates at D; only clear or reset brings it back.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr) begin
            w_cnt_nxt = '0;
        end else if (sh && (r_cnt != D_CNT)) begin
            w_cnt_nxt = r_cnt + {{w{1'b0}}, 1'b1};
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Read data: old word (read-before-write) or post-update word (write-through).
    always_comb begin
        w_rq_nxt = '0;
        if (clr) begin
            w_rq_nxt = '0;
        end else begin
`ifdef REGFL_WIN_BYPASS_EN
            w_rq_nxt = w_mem_nxt[rs];
`else
            w_rq_nxt = r_mem[rs];
`endif
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < D; i++) begin
                r_mem[i] <= '0;
            end
            r_cnt <= '0;
            r_rq  <= '0;
        end else begin
            for (int i = 0; i < D; i++) begin
                r_mem[i] <= w_mem_nxt[i];
            end
            r_cnt <= w_cnt_nxt;
            r_rq  <= w_rq_nxt;
        end
    end

    for (genvar g = 0; g < D; g++) begin : g_flat
        assign q[(g+1)*rgst_w-1 -: rgst_w] = r_mem[g];
    end

    assign rq   = r_rq;
    assign cnt  = r_cnt;
    assign full = (r_cnt == D_CNT);

endmodule
